// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: sequential shift-add-3 binary-to-BCD converter feeding a
// time-multiplexed 7-segment digit bus with leading-zero blanking,
// overflow saturation, ghost blanking and display freeze.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BIN_WIDTH    = 14,
  parameter int unsigned SEL_WIDTH    = 3,
  parameter int unsigned SKIP_SEL     = 2,
  parameter int unsigned DWELL_CYCLES = 1,
  parameter int unsigned BLANK_CYCLES = 0,
  parameter int unsigned LZ_SUPPRESS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BIN_WIDTH-1:0] value,
  input  logic                 freeze,
  output logic [3:0]           digit,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 en,
  output logic                 conv_done,
  output logic                 ovf
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CW    = $clog2(BIN_WIDTH + 1);
  localparam int unsigned SW    = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [63:0] pow10(input int unsigned k);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned j = 0; j < k; j++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]          MAX_VAL    = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0]     ALL_NINES  = {NUM_DIGITS{4'h9}};
  localparam logic [CW-1:0]        SHIFT_LAST = CW'(BIN_WIDTH - 1);
  localparam logic [SW-1:0]        DWELL_LAST = SW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0]        BLANK_C    = SW'(BLANK_CYCLES);
  localparam logic [IW-1:0]        IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_ONE    = SEL_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]     disp_q, disp_d;
  logic                 ovf_q, ovf_d;
  logic                 conv_done_q, conv_done_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [IW-1:0]        idx_q, idx_d;

  logic [BCD_W-1:0]      adj;
  logic [63:0]           val_ext;
  logic [NUM_DIGITS-1:0] zero_above;
  logic                  zacc;
  logic                  blank;
  logic                  suppress;

  // Conversion FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Conversion FSM next state: IDLE, LOAD, BIN_WIDTH x SHIFT, COMMIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_LOAD;
      S_LOAD:   state_d = S_SHIFT;
      S_SHIFT:  if (cnt_q == SHIFT_LAST) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Conversion datapath: load, add-3 then shift, atomic commit to display
  always_comb begin
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    ovf_pend_d  = ovf_pend_q;
    disp_d      = disp_q;
    ovf_d       = ovf_q;
    conv_done_d = 1'b0;
    val_ext     = 64'(value);
    adj         = bcd_q;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    case (state_q)
      S_LOAD: begin
        shift_d    = value;
        bcd_d      = '0;
        cnt_d      = '0;
        ovf_pend_d = (val_ext > MAX_VAL);
      end
      S_SHIFT: begin
        // top BCD bit falls off; it only carries data when saturating anyway
        {bcd_d, shift_d} = {adj[BCD_W-2:0], shift_q, 1'b0};
        cnt_d            = cnt_q + 1'b1;
      end
      S_COMMIT: begin
        if (!freeze) begin
          disp_d      = ovf_pend_q ? ALL_NINES : bcd_q;
          ovf_d       = ovf_pend_q;
          conv_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Conversion and display registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q     <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      disp_q      <= '0;
      ovf_q       <= 1'b0;
      conv_done_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      disp_q      <= disp_d;
      ovf_q       <= ovf_d;
      conv_done_q <= conv_done_d;
    end
  end

  // Scan slot counter and digit index, free-running
  always_comb begin
    slot_d = slot_q;
    idx_d  = idx_q;
    if (slot_q == DWELL_LAST) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      slot_d = slot_q + 1'b1;
    end
  end

  // Scan registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
    end
  end

  // Digit bus outputs: select mapping, ghost blanking, leading-zero blanking
  always_comb begin
    zacc = 1'b1;
    zero_above = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      zacc = zacc & (disp_q[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
      zero_above[NUM_DIGITS-1-j] = zacc;
    end
    digit     = disp_q[4*idx_q +: 4];
    sel       = SEL_WIDTH'(idx_q) + ((32'(idx_q) >= SKIP_SEL) ? SEL_ONE : '0);
    blank     = (BLANK_CYCLES != 0) && (slot_q < BLANK_C);
    suppress  = (LZ_SUPPRESS != 0) && (idx_q != '0) && zero_above[idx_q] && !ovf_q;
    en        = !(blank || suppress);
    conv_done = conv_done_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: default instance plus a dwell/blank instance,
// checked against a value-level model of the display.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1_n, rst2_n;
  logic [13:0] value1, value2;
  logic        freeze1, freeze2;
  logic [3:0]  digit1, digit2;
  logic [2:0]  sel1, sel2;
  logic        en1, en2, done1_o, done2_o, ovf1, ovf2;

  seg_scan_ctrl u_dut1 (
    .clk(clk), .reset_n(rst1_n), .value(value1), .freeze(freeze1),
    .digit(digit1), .sel(sel1), .en(en1), .conv_done(done1_o), .ovf(ovf1)
  );

  seg_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) u_dut2 (
    .clk(clk), .reset_n(rst2_n), .value(value2), .freeze(freeze2),
    .digit(digit2), .sel(sel2), .en(en2), .conv_done(done2_o), .ovf(ovf2)
  );

  int checks = 0;
  int errors = 0;

  // model: edges since reset release, value latched at LOAD, committed value
  int unsigned n1 = 0, n2 = 0;
  int unsigned load1 = 0, disp1 = 0, load2 = 0, disp2 = 0;
  bit          mdone1 = 0, mdone2 = 0;

  function automatic int unsigned pw10(input int unsigned k);
    int unsigned r = 1;
    for (int unsigned j = 0; j < k; j++) r = r * 10;
    return r;
  endfunction

  function automatic logic [3:0] exp_digit(input int unsigned v, input int unsigned i);
    if (v > 9999) return 4'd9;
    return 4'((v / pw10(i)) % 10);
  endfunction

  function automatic logic exp_lit(input int unsigned v, input int unsigned i);
    return (i == 0) || (v > 9999) || ((v / pw10(i)) != 0);
  endfunction

  function automatic logic [2:0] sel_of(input int unsigned i);
    return 3'((i < 2) ? i : i + 1);
  endfunction

  // One clock: update both models on the rising edge, return on the falling edge
  task automatic advance();
    @(posedge clk);
    if (!rst1_n) begin
      n1 = 0; disp1 = 0; mdone1 = 0;
    end else begin
      n1++; mdone1 = 0;
      if (n1 % 17 == 2) load1 = value1;
      if (n1 % 17 == 0 && !freeze1) begin disp1 = load1; mdone1 = 1; end
    end
    if (!rst2_n) begin
      n2 = 0; disp2 = 0; mdone2 = 0;
    end else begin
      n2++; mdone2 = 0;
      if (n2 % 17 == 2) load2 = value2;
      if (n2 % 17 == 0 && !freeze2) begin disp2 = load2; mdone2 = 1; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst1_n = 0; rst2_n = 0; value1 = 0; value2 = 1234; freeze1 = 0; freeze2 = 0;
    repeat (3) advance();
    checks++; if (sel1 !== 3'd0)   begin errors++; $display("FAIL reset_sel1 got %0d exp 0", sel1); end
    checks++; if (digit1 !== 4'd0) begin errors++; $display("FAIL reset_digit1 got %0d exp 0", digit1); end
    checks++; if (en1 !== 1'b1)    begin errors++; $display("FAIL reset_en1 got %b exp 1", en1); end
    checks++; if (ovf1 !== 1'b0)   begin errors++; $display("FAIL reset_ovf1 got %b exp 0", ovf1); end
    checks++; if (done1_o !== 1'b0) begin errors++; $display("FAIL reset_done1 got %b exp 0", done1_o); end
    checks++; if (en2 !== 1'b0)    begin errors++; $display("FAIL reset_en2 got %b exp 0", en2); end
    rst1_n = 1;
  endtask

  // Drive a value into the default instance and check every cycle of the bus
  task automatic test_display(input int unsigned v, input int cycles);
    int unsigned idx;
    value1 = 14'(v);
    for (int c = 0; c < cycles; c++) begin
      advance();
      idx = n1 % 4;
      checks++; if (done1_o !== mdone1) begin errors++; $display("FAIL disp_done v=%0d n=%0d got %b exp %b", v, n1, done1_o, mdone1); end
      checks++; if (ovf1 !== (disp1 > 9999)) begin errors++; $display("FAIL disp_ovf v=%0d n=%0d got %b exp %b", v, n1, ovf1, disp1 > 9999); end
      checks++; if (sel1 !== sel_of(idx)) begin errors++; $display("FAIL disp_sel v=%0d n=%0d got %0d exp %0d", v, n1, sel1, sel_of(idx)); end
      checks++; if (digit1 !== exp_digit(disp1, idx)) begin errors++; $display("FAIL disp_digit v=%0d n=%0d got %0d exp %0d", v, n1, digit1, exp_digit(disp1, idx)); end
      checks++; if (en1 !== exp_lit(disp1, idx)) begin errors++; $display("FAIL disp_en v=%0d n=%0d got %b exp %b", v, n1, en1, exp_lit(disp1, idx)); end
    end
  endtask

  task automatic test_freeze();
    int unsigned idx;
    bit seen;
    test_display(5, 40);
    freeze1 = 1; value1 = 14'd77;
    for (int c = 0; c < 50; c++) begin
      advance();
      idx = n1 % 4;
      checks++; if (done1_o !== 1'b0) begin errors++; $display("FAIL frz_done n=%0d got %b exp 0", n1, done1_o); end
      checks++; if (digit1 !== exp_digit(5, idx)) begin errors++; $display("FAIL frz_digit n=%0d got %0d exp %0d", n1, digit1, exp_digit(5, idx)); end
      checks++; if (en1 !== exp_lit(5, idx)) begin errors++; $display("FAIL frz_en n=%0d got %b exp %b", n1, en1, exp_lit(5, idx)); end
      checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL frz_ovf n=%0d got %b exp 0", n1, ovf1); end
    end
    freeze1 = 0;
    seen = 0;
    for (int c = 0; c < 34 && !seen; c++) begin
      advance();
      seen = done1_o;
    end
    checks++; if (!seen) begin errors++; $display("FAIL unfreeze_done got none exp pulse within 34"); end
    for (int c = 0; c < 8; c++) begin
      advance();
      idx = n1 % 4;
      checks++; if (digit1 !== exp_digit(77, idx)) begin errors++; $display("FAIL unfreeze_digit n=%0d got %0d exp %0d", n1, digit1, exp_digit(77, idx)); end
      checks++; if (en1 !== exp_lit(77, idx)) begin errors++; $display("FAIL unfreeze_en n=%0d got %b exp %b", n1, en1, exp_lit(77, idx)); end
    end
  endtask

  // Dwell/blank instance; reset is asserted mid-SHIFT
  task automatic test_dwell_reset();
    int unsigned idx, slot;
    rst2_n = 1;
    for (int c = 0; c < 120; c++) begin
      if (c == 60) value2 = 14'd15000;
      advance();
      idx = (n2 / 4) % 4; slot = n2 % 4;
      checks++; if (done2_o !== mdone2) begin errors++; $display("FAIL dw_done n=%0d got %b exp %b", n2, done2_o, mdone2); end
      checks++; if (ovf2 !== (disp2 > 9999)) begin errors++; $display("FAIL dw_ovf n=%0d got %b exp %b", n2, ovf2, disp2 > 9999); end
      checks++; if (sel2 !== sel_of(idx)) begin errors++; $display("FAIL dw_sel n=%0d got %0d exp %0d", n2, sel2, sel_of(idx)); end
      checks++; if (digit2 !== exp_digit(disp2, idx)) begin errors++; $display("FAIL dw_digit n=%0d got %0d exp %0d", n2, digit2, exp_digit(disp2, idx)); end
      checks++; if (en2 !== ((slot != 0) && exp_lit(disp2, idx))) begin errors++; $display("FAIL dw_en n=%0d got %b exp %b", n2, en2, (slot != 0) && exp_lit(disp2, idx)); end
    end
    for (int c = 0; c < 17 && (n2 % 17 != 8); c++) advance();
    checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL dw_pre_rst_ovf got %b exp 1", ovf2); end
    rst2_n = 0;
    #1;
    checks++; if (sel2 !== 3'd0)   begin errors++; $display("FAIL dw_rst_sel got %0d exp 0", sel2); end
    checks++; if (digit2 !== 4'd0) begin errors++; $display("FAIL dw_rst_digit got %0d exp 0", digit2); end
    checks++; if (en2 !== 1'b0)    begin errors++; $display("FAIL dw_rst_en got %b exp 0", en2); end
    checks++; if (ovf2 !== 1'b0)   begin errors++; $display("FAIL dw_rst_ovf got %b exp 0", ovf2); end
    advance(); advance();
    rst2_n = 1;
    for (int c = 1; c <= 20; c++) begin
      advance();
      checks++; if (done2_o !== (c == 17)) begin errors++; $display("FAIL dw_rel_done n=%0d got %b exp %b", c, done2_o, c == 17); end
      checks++; if (ovf2 !== (c >= 17)) begin errors++; $display("FAIL dw_rel_ovf n=%0d got %b exp %b", c, ovf2, c >= 17); end
    end
  endtask

  initial begin
    test_reset();
    test_display(0, 34);
    test_display(1234, 40);
    test_display(40, 40);
    test_display(12000, 40);
    test_display(9999, 40);
    test_freeze();
    for (int k = 0; k < 4; k++) test_display($urandom_range(0, 16383), 40);
    test_dwell_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
